mult_rr_sched_4req: RTL and testbench

MULT_RR_SCHED_4REQ -- requirements
Module: mult_rr_sched_4req

---
 rtl/mult_rr_sched_4req.sv | 88 ++++++++
 tb/tb_mult_rr_sched_4req.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_sched_4req.sv
// Four-requester round-robin front end for a shared pipelined 8x8 signed multiplier.
// Optional MULT_SCHED_STATS_EN adds a saturating issue_cnt transfer counter.
module mult_rr_sched_4req #(
  parameter int unsigned LATENCY = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        hold,
  output logic [3:0]  gnt,
  output logic [7:0]  mult_a,
  output logic [7:0]  mult_b,
  input  logic [15:0] mult_y,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [15:0] rsp_y,
  output logic        idle
`ifdef MULT_SCHED_STATS_EN
  ,
  output logic [15:0] issue_cnt
`endif
);

  logic [1:0]         ptr;
  logic [1:0]         cand;
  logic [1:0]         gnt_idx;
  logic               gnt_any;
  logic [LATENCY-1:0] tag_v;
  logic [1:0]         tag_id [LATENCY];

  // ptr holds the index with highest priority this cycle (last granted + 1)
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (hold || reset) gnt_any = 1'b0;
  end

  always_comb begin
    gnt    = gnt_any ? (4'b0001 << gnt_idx) : '0;
    mult_a = gnt_any ? a_in[{gnt_idx, 3'b000} +: 8] : '0;
    mult_b = gnt_any ? b_in[{gnt_idx, 3'b000} +: 8] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      tag_v <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) tag_id[k] <= '0;
    end else begin
      if (gnt_any) ptr <= gnt_idx + 2'd1;
      tag_v[0]  <= gnt_any;
      tag_id[0] <= gnt_idx;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // Last tag stage lines up with the multiplier output of the same transfer
  always_comb begin
    rsp_valid = tag_v[LATENCY-1];
    rsp_id    = rsp_valid ? tag_id[LATENCY-1] : '0;
    rsp_y     = rsp_valid ? mult_y : '0;
    idle      = ~((|tag_v) | gnt_any);
  end

`ifdef MULT_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt <= '0;
    end else if (gnt_any && (issue_cnt != '1)) begin
      issue_cnt <= issue_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_rr_sched_4req.sv
// Directed bench for mult_rr_sched_4req with a behavioural 8-stage signed multiplier.
module tb_mult_rr_sched_4req;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        hold;
  logic [3:0]  gnt;
  logic [7:0]  mult_a;
  logic [7:0]  mult_b;
  logic [15:0] mult_y;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_y;
  logic        idle;
`ifdef MULT_SCHED_STATS_EN
  logic [15:0] issue_cnt;
`endif

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  mult_rr_sched_4req #(.LATENCY(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .a_in(a_in),
    .b_in(b_in),
    .hold(hold),
    .gnt(gnt),
    .mult_a(mult_a),
    .mult_b(mult_b),
    .mult_y(mult_y),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_y(rsp_y),
    .idle(idle)
`ifdef MULT_SCHED_STATS_EN
    ,
    .issue_cnt(issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] mpipe [LAT] = '{default: '0};
  always_ff @(posedge clk) begin
    mpipe[0] <= $signed(mult_a) * $signed(mult_b);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mult_y = mpipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    oh2i = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) oh2i = 2'(i);
  endfunction

  // Stream scenario: operands per requester and their hand-computed products
  logic [7:0]  opa  [4] = '{8'h02, 8'hFF, 8'h7F, 8'h80};
  logic [7:0]  opb  [4] = '{8'h03, 8'h07, 8'h7F, 8'h7F};
  logic [15:0] prod [4] = '{16'h0006, 16'hFFF9, 16'h3F01, 16'hC080};
  logic [3:0]  exp_gnt [25] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2,
    4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  initial begin
    logic [3:0] past;
    logic       busy;

    reset = 1'b1; req = 4'b1111; a_in = 32'h807FFF02; b_in = 32'h7F7F0703; hold = 1'b0;
    #3;
    chk("rst_gnt", gnt, 4'h0);
    chk("rst_mult_a", mult_a, 8'h00);
    chk("rst_mult_b", mult_b, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_y", rsp_y, 16'h0000);
    chk("rst_idle", idle, 1'b1);
    tick();
    tick();

    // -128 * -128 from requester 0
    reset = 1'b0; req = 4'b0001; a_in = 32'h00000080; b_in = 32'h00000080;
    #1;
    chk("r0_gnt", gnt, 4'h1);
    chk("r0_mult_a", mult_a, 8'h80);
    chk("r0_mult_b", mult_b, 8'h80);
    chk("r0_idle", idle, 1'b0);
    tick();
    req = 4'b0000; a_in = '0; b_in = '0;
    #1;
    chk("r0_nogrant_gnt", gnt, 4'h0);
    chk("r0_nogrant_mult_a", mult_a, 8'h00);
    chk("r0_inflight_idle", idle, 1'b0);
    chk("r0_early_valid", rsp_valid, 1'b0);
    for (int i = 2; i < LAT; i++) begin
      tick(); #1;
      chk("r0_early_valid", rsp_valid, 1'b0);
    end
    tick(); #1;
    chk("r0_rsp_valid", rsp_valid, 1'b1);
    chk("r0_rsp_id", rsp_id, 2'd0);
    chk("r0_rsp_y", rsp_y, 16'h4000);
    tick(); #1;
    chk("r0_after_valid", rsp_valid, 1'b0);
    chk("r0_after_y", rsp_y, 16'h0000);
    chk("r0_after_idle", idle, 1'b1);

    // -3 * 5 from requester 2
    req = 4'b0100; a_in = 32'h00FD0000; b_in = 32'h00050000;
    #1;
    chk("r2_gnt", gnt, 4'h4);
    chk("r2_mult_a", mult_a, 8'hFD);
    chk("r2_mult_b", mult_b, 8'h05);
    for (int i = 1; i < LAT; i++) begin
      tick();
      req = 4'b0000;
      #1;
      chk("r2_early_valid", rsp_valid, 1'b0);
    end
    tick(); #1;
    chk("r2_rsp_valid", rsp_valid, 1'b1);
    chk("r2_rsp_id", rsp_id, 2'd2);
    chk("r2_rsp_y", rsp_y, 16'hFFF1);

    // Full-load stream with hold during cycles 10..12
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; a_in = 32'h807FFF02; b_in = 32'h7F7F0703;
    for (int c = 0; c < 25; c++) begin
      tick();
      hold = (c >= 10 && c <= 12);
      req  = (c < 15) ? 4'b1111 : 4'b0000;
      #1;
      chk("stream_gnt", gnt, exp_gnt[c]);
      if (exp_gnt[c] != 4'h0) begin
        chk("stream_mult_a", mult_a, opa[oh2i(exp_gnt[c])]);
        chk("stream_mult_b", mult_b, opb[oh2i(exp_gnt[c])]);
      end else begin
        chk("stream_mult_a_zero", mult_a, 8'h00);
      end
      past = (c >= LAT) ? exp_gnt[c-LAT] : 4'h0;
      chk("stream_rsp_valid", rsp_valid, past != 4'h0);
      if (past != 4'h0) begin
        chk("stream_rsp_id", rsp_id, oh2i(past));
        chk("stream_rsp_y", rsp_y, prod[oh2i(past)]);
      end else begin
        chk("stream_rsp_y_zero", rsp_y, 16'h0000);
      end
      busy = 1'b0;
      for (int k = 0; k <= LAT; k++) begin
        if (c >= k) begin
          if (exp_gnt[c-k] != 4'h0) busy = 1'b1;
        end
      end
      chk("stream_idle", idle, !busy);
    end
    hold = 1'b0;

    // Three transfers, then reset four cycles later discards them
    tick(); req = 4'b1111; #1;
    chk("flush_gnt0", gnt, 4'h1);
    tick(); #1;
    chk("flush_gnt1", gnt, 4'h2);
    tick(); #1;
    chk("flush_gnt2", gnt, 4'h4);
    for (int i = 0; i < 3; i++) begin
      tick(); req = 4'b0000; #1;
      chk("flush_inflight_idle", idle, 1'b0);
    end
    tick();
    reset = 1'b1; req = 4'b1111;
    #1;
    chk("flush_rst_gnt", gnt, 4'h0);
    chk("flush_rst_mult_a", mult_a, 8'h00);
    chk("flush_rst_valid", rsp_valid, 1'b0);
    chk("flush_rst_idle", idle, 1'b1);
    tick();
    reset = 1'b0; req = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick(); #1;
      chk("flush_no_valid", rsp_valid, 1'b0);
      chk("flush_idle", idle, 1'b1);
    end
    tick(); req = 4'b1111; #1;
    chk("flush_first_gnt", gnt, 4'h1);
    tick(); req = 4'b0000;

`ifdef MULT_SCHED_STATS_EN
    reset = 1'b1;
    #1;
    chk("stats_rst", issue_cnt, 16'h0000);
    tick();
    reset = 1'b0; req = 4'b0001;
    for (int i = 0; i < 65537; i++) tick();
    req = 4'b0000;
    tick(); #1;
    chk("stats_sat", issue_cnt, 16'hFFFF);
    reset = 1'b1;
    #1;
    chk("stats_clear", issue_cnt, 16'h0000);
    tick();
    reset = 1'b0;
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
